// File: rtl/audio_pkg.sv
// Shared types and defaults for the alarm-tone generator.
// Optional feature macro: AUDIO_REPEAT_EN.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_HALF_PERIOD = 113636;
  localparam int DEF_BEEP_CYCLES = 25_000_000;
  localparam int DEF_GAP_CYCLES  = 25_000_000;
  localparam int DEF_BEEPS       = 3;

  // Bits needed to hold 0..max.
  function automatic int cw(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audio_tone_gen.sv
// Square-wave source: half-period counter plus toggle flop.
// Output is registered and held at 0 while disabled.
module tone_gen
  import audio_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tone
);

  localparam int HW = cw(HALF_PERIOD);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          tog_q, tog_d;

  // Next phase: restart high, toggle at end of each half period.
  always_comb begin
    hcnt_d = '0;
    tog_d  = 1'b0;
    if (!en) begin
      hcnt_d = '0;
      tog_d  = 1'b0;
    end else if (restart) begin
      hcnt_d = '0;
      tog_d  = 1'b1;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      tog_d  = !tog_q;
    end else begin
      hcnt_d = hcnt_q + HW'(1);
      tog_d  = tog_q;
    end
  end

  // Phase state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      tog_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      tog_q  <= tog_d;
    end
  end

  assign tone = tog_q;

endmodule

// File: rtl/audio.sv
// Alarm beeper: edge detect on cronofin, beep/gap FSM, tone source.
// Optional feature macro: AUDIO_REPEAT_EN (loop while cronofin held).
module audio
  import audio_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int BEEP_CYCLES = DEF_BEEP_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int BEEPS       = DEF_BEEPS
) (
  input  logic clk,
  input  logic rst,
  input  logic cronofin,
  output logic sonido
);

  localparam int CW = cw(max2(BEEP_CYCLES, GAP_CYCLES));
  localparam int BW = cw(BEEPS);
  localparam logic [CW-1:0] B_LAST  = CW'(BEEP_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BEEPS_N = BW'(BEEPS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          prev_q;
  logic          trig;
  logic          en;
  logic          restart;

  assign trig = cronofin && !prev_q;

  // Beep/gap sequencing; counters clear on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = TONE;
          cnt_d   = '0;
          beep_d  = BW'(1);
        end
      end
      TONE: begin
        if (cnt_q == B_LAST) begin
          cnt_d = '0;
          if (beep_q < BEEPS_N) begin
            state_d = GAP;
          end else begin
`ifdef AUDIO_REPEAT_EN
            state_d = GAP;
`else
            state_d = IDLE;
            beep_d  = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = TONE;
          beep_d  = beep_q + BW'(1);
`ifdef AUDIO_REPEAT_EN
          if (beep_q >= BEEPS_N) begin
            if (cronofin) begin
              beep_d = BW'(1);
            end else begin
              state_d = IDLE;
              beep_d  = '0;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        beep_d  = '0;
      end
    endcase
  end

  // Tone runs whenever the next state is TONE; phase restarts on entry.
  assign en      = (state_d == TONE);
  assign restart = en && (state_q != TONE);

  // FSM, counters and edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beep_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
      prev_q  <= cronofin;
    end
  end

  tone_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .tone   (sonido)
  );

endmodule

// File: tb/tb_audio.sv
// Directed scoreboard bench for the alarm beeper.
// Build with AUDIO_REPEAT_EN to exercise the looping variant.
module tb_audio;

  localparam int HP  = 4;
  localparam int BC  = 16;
  localparam int GC  = 8;
  localparam int NB  = 2;
  localparam int SEQ = NB * (BC + GC);
  localparam int ONE = NB * BC + (NB - 1) * GC;

  logic clk = 1'b0;
  logic rst;
  logic cronofin;
  logic sonido;

  int n_cmp = 0;
  int n_bad = 0;
  logic expq[$];

  always #5 clk = ~clk;

  audio #(
    .HALF_PERIOD(HP),
    .BEEP_CYCLES(BC),
    .GAP_CYCLES (GC),
    .BEEPS      (NB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cronofin(cronofin),
    .sonido  (sonido)
  );

  // Expected output t cycles after the trigger edge.
  function automatic logic model(int t, int stop, bit rep);
    int p, b;
    if (t >= stop) return 1'b0;
    if (rep) t = t % SEQ;
    b = t / (BC + GC);
    p = t % (BC + GC);
    if (b >= NB) return 1'b0;
    if (p >= BC) return 1'b0;
    return ((p / HP) % 2) == 0;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: sonido=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_pat(int n, int stop, bit rep);
    for (int t = 0; t < n; t++) expq.push_back(model(t, stop, rep));
  endtask

  task automatic push_zero(int n);
    for (int t = 0; t < n; t++) expq.push_back(1'b0);
  endtask

  // Step one cycle per expected entry, apply scheduled events, compare.
  task automatic drain(string tag, int c_off, int c_on2, int c_off2,
                       int r_at);
    int i;
    i = 0;
    while (expq.size() > 0) begin
      @(posedge clk);
      #1;
      if (i == c_off)  cronofin = 1'b0;
      if (i == c_on2)  cronofin = 1'b1;
      if (i == c_off2) cronofin = 1'b0;
      if (i == r_at) begin
        rst = 1'b0;
        #1;
      end
      chk($sformatf("%s[%0d]", tag, i), sonido, expq.pop_front());
      i++;
    end
  endtask

  initial begin
    rst      = 1'b0;
    cronofin = 1'b0;

    // Reset with cronofin low: silent for 100 cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", sonido, 1'b0);
    rst = 1'b1;
    push_zero(100);
    drain("idle", -1, -1, -1, -1);

    // cronofin held through reset release.
    rst = 1'b0;
    cronofin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", sonido, 1'b0);
    rst = 1'b1;
`ifdef AUDIO_REPEAT_EN
    push_pat(SEQ * 3 + 20, SEQ * 3, 1'b1);
    drain("repeat", SEQ * 2 + 10, -1, -1, -1);
`else
    push_pat(ONE + 20, ONE, 1'b0);
    drain("held", -1, -1, -1, -1);
    cronofin = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // Single-cycle pulse, second pulse at cycle 10 ignored.
    cronofin = 1'b1;
    push_pat(ONE + 20, ONE, 1'b0);
    drain("pulse", 0, 9, 10, -1);

    // Reset mid-beep forces silence and loses the sequence.
    cronofin = 1'b1;
    for (int t = 0; t < 30; t++)
      expq.push_back(t < 2 ? model(t, ONE, 1'b0) : 1'b0);
    drain("midrst", 0, -1, -1, 2);
    rst = 1'b1;
    push_zero(30);
    drain("postrst", -1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
